// File: rtl/ucode_sequencer.sv
// ucode_sequencer
// Multi-cycle microcode sequencer. Accepts one opcode per valid/ready handshake
// and walks it through DECODE, optional OPERAND fetch (RAM), EXEC and one or
// more writeback beats, emitting per-phase control strobes.
//
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   opcode, op_valid      : instruction byte and its valid flag
//   op_ready              : high when the sequencer can accept an opcode
//   carry, zero, sign     : ALU flags, evaluated by jumps during EXEC
//   flush                 : abort the instruction in flight
//   mem_ack / mem_req     : RAM operand handshake
//   alu_operation, alu_op : ALU execute strobe and function
//   mov_operation         : move strobe, source_ports selects port source
//   jump_taken            : branch strobe (condition result)
//   stack_operation       : stack strobe, stack_direction 1 = push / 0 = pop
//   dest_w/registers/memory/ports, dest_index : writeback target
//   wb_beat               : current writeback beat number
//   done, illegal_op, mem_timeout : completion / error pulses
module ucode_sequencer #(
  parameter int INDEX_WIDTH    = 3,
  parameter int WB_BEATS_MULTI = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             opcode,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic                   carry,
  input  logic                   zero,
  input  logic                   sign,
  input  logic                   flush,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   alu_operation,
  output logic [2:0]             alu_op,
  output logic                   mov_operation,
  output logic                   jump_taken,
  output logic                   stack_operation,
  output logic                   stack_direction,
  output logic                   dest_w,
  output logic                   dest_registers,
  output logic                   dest_memory,
  output logic                   dest_ports,
  output logic                   source_ports,
  output logic [INDEX_WIDTH-1:0] dest_index,
  output logic [1:0]             wb_beat,
  output logic                   done,
  output logic                   illegal_op,
  output logic                   mem_timeout
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int BW = (WB_BEATS_MULTI > 4) ? $clog2(WB_BEATS_MULTI) : 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    WB      = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      op_q;
  logic [TW-1:0]   wait_cnt;
  logic [BW-1:0]   beat_cnt;

  logic is_alu, is_mov, is_jmp, is_stk;
  logic multibyte, ram_operand, is_push, cond_illegal;
  logic last_beat, timed_out, cond_met, active;

  assign is_alu       = (op_q[7:6] == 2'b00);
  assign is_mov       = (op_q[7:6] == 2'b01);
  assign is_jmp       = (op_q[7:6] == 2'b10);
  assign is_stk       = (op_q[7:6] == 2'b11);
  assign multibyte    = is_alu && op_q[5];
  assign ram_operand  = is_alu && op_q[4];
  assign is_push      = is_stk && op_q[5];
  assign cond_illegal = is_jmp && (op_q[5:3] == 3'b111);

  // Only multibyte ALU results take more than one writeback beat.
  assign last_beat = multibyte ? (beat_cnt == BW'(WB_BEATS_MULTI - 1))
                               : (beat_cnt == '0);
  assign timed_out = (wait_cnt == TW'(MEM_TIMEOUT - 1));

  // Strobes are suppressed while reset or flush is asserted; IDLE drives none
  // of them anyway, so ignoring flush in IDLE falls out naturally.
  assign active = !reset && !flush;

  // Sequencer state. Flush only acts outside IDLE, so an accept in the same
  // cycle as an IDLE flush still goes through. An ack on the last allowed
  // OPERAND cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else if (flush && state != IDLE) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q  <= opcode;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (cond_illegal) begin
            state <= IDLE;
          end else if (ram_operand) begin
            wait_cnt <= '0;
            state    <= OPERAND;
          end else begin
            state <= EXEC;
          end
        end
        OPERAND: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            state    <= EXEC;
          end else if (timed_out) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        EXEC: begin
          beat_cnt <= '0;
          if (is_jmp || is_push) state <= IDLE;
          else                   state <= WB;
        end
        WB: begin
          if (last_beat) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Jump condition, evaluated against the live flags during EXEC.
  always_comb begin
    cond_met = 1'b0;
    case (op_q[5:3])
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = zero;
      3'b010:  cond_met = !zero;
      3'b011:  cond_met = carry;
      3'b100:  cond_met = !carry;
      3'b101:  cond_met = sign;
      3'b110:  cond_met = !sign;
      default: cond_met = 1'b0;
    endcase
  end

  // Output decode from the registered state and latched opcode.
  always_comb begin
    op_ready        = (state == IDLE) && !reset;
    mem_req         = 1'b0;
    alu_operation   = 1'b0;
    alu_op          = 3'b000;
    mov_operation   = 1'b0;
    jump_taken      = 1'b0;
    stack_operation = 1'b0;
    stack_direction = 1'b0;
    dest_w          = 1'b0;
    dest_registers  = 1'b0;
    dest_memory     = 1'b0;
    dest_ports      = 1'b0;
    source_ports    = 1'b0;
    dest_index      = '0;
    wb_beat         = 2'b00;
    done            = 1'b0;
    illegal_op      = 1'b0;
    mem_timeout     = 1'b0;
    if (!reset && state != IDLE) begin
      dest_index = op_q[INDEX_WIDTH-1:0];
    end
    if (active) begin
      case (state)
        DECODE: begin
          illegal_op = cond_illegal;
        end
        OPERAND: begin
          mem_req     = 1'b1;
          mem_timeout = timed_out && !mem_ack;
        end
        EXEC: begin
          alu_operation   = is_alu;
          alu_op          = is_alu ? op_q[2:0] : 3'b000;
          mov_operation   = is_mov;
          source_ports    = is_mov && op_q[3];
          stack_operation = is_stk;
          stack_direction = is_push;
          jump_taken      = is_jmp && cond_met;
          done            = is_jmp || is_push;
        end
        WB: begin
          wb_beat        = beat_cnt[1:0];
          dest_w         = is_alu;
          dest_registers = (is_mov && op_q[5:4] == 2'b01) || is_stk;
          dest_memory    = is_mov && op_q[5:4] == 2'b10;
          dest_ports     = is_mov && op_q[5:4] == 2'b11;
          if (is_mov && op_q[5:4] == 2'b00) dest_w = 1'b1;
          done           = last_beat;
        end
        default: ;
      endcase
    end
  end

endmodule
